// File: rtl/common.sv
// ---------------------------------------------------------------------------
// common -- shared constants and types for the integer pipeline.
//   XLEN        : datapath width
//   REG_ADDR_W  : architectural register address width
//   NUM_REGS    : number of architectural registers (x0..x31)
//   word_t      : one XLEN-bit data word
//   reg_addr_t  : one register address
// ---------------------------------------------------------------------------
package common;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard -- per-register pending-write counters and issue interlock.
//   clk, rst        : clock, asynchronous active-low reset
//   w_enable/w_addr : writeback retiring a write (decrements the counter)
//   rs1/rs2_addr    : source operands of the instruction at decode
//   issue_valid     : decode presents an instruction
//   issue_reg_write : that instruction writes issue_rd
//   issue_rd        : its destination (increments the counter when accepted)
//   kill_valid/rd   : flushed in-flight writer (decrements the counter)
//   stall           : issue blocked this cycle
//   issue_ok        : issue accepted this cycle
// ---------------------------------------------------------------------------
module reg_scoreboard
  import common::*;
#(
  parameter int BYPASS = 1,
  parameter int CNT_W  = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      w_enable,
  input  reg_addr_t w_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  input  logic      issue_valid,
  input  logic      issue_reg_write,
  input  reg_addr_t issue_rd,
  input  logic      kill_valid,
  input  reg_addr_t kill_rd,
  output logic      stall,
  output logic      issue_ok
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = {CNT_W{1'b1}};
  localparam cnt_t CNT_ONE = cnt_t'(1);

  cnt_t cnt      [NUM_REGS];
  cnt_t cnt_next [NUM_REGS];

  logic rs1_busy;
  logic rs2_busy;
  logic rd_full;

  logic             inc;
  logic             dec_w;
  logic             dec_k;
  logic [CNT_W:0]   sum;
  logic [CNT_W:0]   dec;

  // A source is not busy when its only outstanding writer retires this very
  // cycle and the register file forwards that write data.
  function automatic logic is_busy(input reg_addr_t a, input cnt_t c,
                                   input logic wen, input reg_addr_t wa);
    logic busy;
    busy = 1'b1;
    if (a == '0 || c == '0)
      busy = 1'b0;
    else if (BYPASS != 0 && c == CNT_ONE && wen && wa == a)
      busy = 1'b0;
    return busy;
  endfunction

  // Counters are held at zero in reset, so stall drops and issue_ok follows
  // issue_valid without any explicit reset gating here.
  always_comb begin
    rs1_busy = is_busy(rs1_addr, cnt[rs1_addr], w_enable, w_addr);
    rs2_busy = is_busy(rs2_addr, cnt[rs2_addr], w_enable, w_addr);
    rd_full  = issue_reg_write && (issue_rd != '0) && (cnt[issue_rd] == CNT_MAX);
    stall    = issue_valid && (rs1_busy || rs2_busy || rd_full);
    issue_ok = issue_valid && !stall;
  end

  // Net delta = +issue -writeback -kill. Over-decrement clamps at zero;
  // overflow is impossible because a full counter stalls the issue.
  always_comb begin
    inc   = 1'b0;
    dec_w = 1'b0;
    dec_k = 1'b0;
    sum   = '0;
    dec   = '0;
    cnt_next[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc   = issue_ok && issue_reg_write && (issue_rd == REG_ADDR_W'(r));
      dec_w = w_enable && (w_addr == REG_ADDR_W'(r));
      dec_k = kill_valid && (kill_rd == REG_ADDR_W'(r));
      sum   = {1'b0, cnt[r]} + (CNT_W+1)'(inc);
      dec   = (CNT_W+1)'(dec_w) + (CNT_W+1)'(dec_k);
      if (sum < dec)
        cnt_next[r] = '0;
      else
        cnt_next[r] = cnt_t'(sum - dec);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= cnt_next[r];
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb -- 32 x 32-bit register file with write bypass and an issue
// scoreboard tracking in-flight writes per register.
//   clk, rst          : clock, asynchronous active-low reset
//   w_enable/w_addr/w_data : writeback port
//   rs1_addr/rs2_addr : read addresses; rs1_data/rs2_data combinational
//   issue_valid, issue_reg_write, issue_rd : instruction at decode
//   kill_valid, kill_rd : flushed writer that will never write back
//   stall, issue_ok   : issue interlock outputs
// ---------------------------------------------------------------------------
module regfile_sb
  import common::*;
#(
  parameter int BYPASS = 1,
  parameter int CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_enable,
  input  logic [REG_ADDR_W-1:0] w_addr,
  input  logic [XLEN-1:0]       w_data,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  input  logic                  issue_valid,
  input  logic                  issue_reg_write,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  kill_valid,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  output logic                  stall,
  output logic                  issue_ok
);

  word_t regs [NUM_REGS];
  logic  wr_live;

  // x0 is cleared by reset and never written, so it stays zero in storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
    end else if (w_enable && w_addr != '0) begin
      regs[w_addr] <= w_data;
    end
  end

  // Forwarding is suppressed in reset so reads return zero there even if the
  // writeback port is toggling.
  always_comb begin
    wr_live = rst && w_enable && (w_addr != '0);

    if (rs1_addr == '0)
      rs1_data = '0;
    else if (BYPASS != 0 && wr_live && w_addr == rs1_addr)
      rs1_data = w_data;
    else
      rs1_data = regs[rs1_addr];

    if (rs2_addr == '0)
      rs2_data = '0;
    else if (BYPASS != 0 && wr_live && w_addr == rs2_addr)
      rs2_data = w_data;
    else
      rs2_data = regs[rs2_addr];
  end

  reg_scoreboard #(
    .BYPASS (BYPASS),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk             (clk),
    .rst             (rst),
    .w_enable        (w_enable),
    .w_addr          (w_addr),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .issue_valid     (issue_valid),
    .issue_reg_write (issue_reg_write),
    .issue_rd        (issue_rd),
    .kill_valid      (kill_valid),
    .kill_rd         (kill_rd),
    .stall           (stall),
    .issue_ok        (issue_ok)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb -- drives one BYPASS=1 and one BYPASS=0 regfile_sb from the
// same inputs. Each directed vector queues its hand-computed outputs; a
// monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        iv;
    logic        irw;
    logic [4:0]  rd;
    logic        kv;
    logic [4:0]  krd;
  } stim_t;

  typedef struct {
    string       name;
    logic [31:0] r1_b;
    logic [31:0] r2_b;
    logic        st_b;
    logic        ok_b;
    logic [31:0] r1_n;
    logic [31:0] r2_n;
    logic        st_n;
    logic        ok_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_enable = 1'b0;
  logic [4:0]  w_addr = '0;
  logic [31:0] w_data = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        issue_valid = 1'b0;
  logic        issue_reg_write = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        kill_valid = 1'b0;
  logic [4:0]  kill_rd = '0;

  logic [31:0] rs1_b, rs2_b, rs1_n, rs2_n;
  logic        stall_b, ok_b, stall_n, ok_n;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors_applied = 0;
  int   miscompares = 0;

  regfile_sb #(.BYPASS(1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_b), .rs2_data(rs2_b),
    .issue_valid(issue_valid), .issue_reg_write(issue_reg_write), .issue_rd(issue_rd),
    .kill_valid(kill_valid), .kill_rd(kill_rd), .stall(stall_b), .issue_ok(ok_b)
  );

  regfile_sb #(.BYPASS(0), .CNT_W(2)) dut_nb (
    .clk(clk), .rst(rst), .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_n), .rs2_data(rs2_n),
    .issue_valid(issue_valid), .issue_reg_write(issue_reg_write), .issue_rd(issue_rd),
    .kill_valid(kill_valid), .kill_rd(kill_rd), .stall(stall_n), .issue_ok(ok_n)
  );

  always #5 clk = ~clk;

  function automatic stim_t S(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] a1, input logic [4:0] a2,
                              input logic iv, input logic irw, input logic [4:0] rd,
                              input logic kv, input logic [4:0] krd);
    stim_t s;
    s.we = we; s.wa = wa; s.wd = wd; s.a1 = a1; s.a2 = a2;
    s.iv = iv; s.irw = irw; s.rd = rd; s.kv = kv; s.krd = krd;
    return s;
  endfunction

  function automatic exp_t E(input logic [31:0] r1b, input logic [31:0] r2b,
                             input logic stb, input logic okb,
                             input logic [31:0] r1n, input logic [31:0] r2n,
                             input logic stn, input logic okn);
    exp_t e;
    e.name = "";
    e.r1_b = r1b; e.r2_b = r2b; e.st_b = stb; e.ok_b = okb;
    e.r1_n = r1n; e.r2_n = r2n; e.st_n = stn; e.ok_n = okn;
    return e;
  endfunction

  function automatic exp_t E2(input logic [31:0] r1, input logic [31:0] r2,
                              input logic st, input logic ok);
    return E(r1, r2, st, ok, r1, r2, st, ok);
  endfunction

  task automatic drive(input stim_t s);
    w_enable = s.we; w_addr = s.wa; w_data = s.wd;
    rs1_addr = s.a1; rs2_addr = s.a2;
    issue_valid = s.iv; issue_reg_write = s.irw; issue_rd = s.rd;
    kill_valid = s.kv; kill_rd = s.krd;
  endtask

  task automatic applyStimulus(input string name, input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    drive(s);
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Drops reset two time units after a rising edge, away from any clock edge.
  task automatic applyAsyncReset(input string name, input stim_t s, input exp_t e);
    @(posedge clk);
    #2;
    rst = 1'b0;
    drive(s);
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    #1;
    drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
  endtask

  task automatic cmp(input string vec, input string fld,
                     input logic [31:0] act, input logic [31:0] want);
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s.%s: got %h, want %h", vec, fld, act, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    vectors_applied++;
    cmp(e.name, "rs1_byp",   rs1_b,          e.r1_b);
    cmp(e.name, "rs2_byp",   rs2_b,          e.r2_b);
    cmp(e.name, "stall_byp", {31'b0, stall_b}, {31'b0, e.st_b});
    cmp(e.name, "ok_byp",    {31'b0, ok_b},    {31'b0, e.ok_b});
    cmp(e.name, "rs1_nob",   rs1_n,          e.r1_n);
    cmp(e.name, "rs2_nob",   rs2_n,          e.r2_n);
    cmp(e.name, "stall_nob", {31'b0, stall_n}, {31'b0, e.st_n});
    cmp(e.name, "ok_nob",    {31'b0, ok_n},    {31'b0, e.ok_n});
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput(mon_e);
    end
  end

  initial begin
    #1 rst = 1'b0;

    // Reset: bypass gated off, issue passes straight through, writes ignored.
    applyStimulus("in_reset", S(1, 5, 32'h11, 5, 0, 1, 1, 9, 0, 0), E2(0, 0, 0, 1));
    releaseReset();

    applyStimulus("wr_x5",   S(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0), E2(0, 0, 0, 0));
    applyStimulus("rd_x5",   S(1, 0, 32'h1234, 5, 0, 0, 0, 0, 0, 0), E2(32'hDEADBEEF, 0, 0, 0));
    applyStimulus("rd_x0",   S(0, 0, 0, 5, 0, 0, 0, 0, 0, 0), E2(32'hDEADBEEF, 0, 0, 0));
    applyStimulus("byp_x7",  S(1, 7, 32'hA5A5A5A5, 5, 7, 0, 0, 0, 0, 0),
                  E(32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 32'hDEADBEEF, 0, 0, 0));
    applyStimulus("x7_next", S(0, 0, 0, 0, 7, 0, 0, 0, 0, 0), E2(0, 32'hA5A5A5A5, 0, 0));

    // RAW on x3 resolved by same-cycle writeback only with bypass.
    applyStimulus("iss_rd3",   S(0, 0, 0, 0, 0, 1, 1, 3, 0, 0), E2(0, 0, 0, 1));
    applyStimulus("raw3_stall", S(0, 0, 0, 3, 0, 1, 0, 0, 0, 0), E2(0, 0, 1, 0));
    applyStimulus("raw3_wb",   S(1, 3, 32'h33, 3, 0, 1, 0, 0, 0, 0),
                  E(32'h33, 0, 0, 1, 0, 0, 1, 0));
    applyStimulus("x3_free",   S(0, 0, 0, 3, 0, 1, 0, 0, 0, 0), E2(32'h33, 0, 0, 1));

    // Fill x9 to the counter maximum, then free one slot with a kill.
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("iss9_%0d", i), S(0, 0, 0, 0, 0, 1, 1, 9, 0, 0), E2(0, 0, 0, 1));
    applyStimulus("iss9_full",  S(0, 0, 0, 0, 0, 1, 1, 9, 0, 0), E2(0, 0, 1, 0));
    applyStimulus("kill9",      S(0, 0, 0, 0, 0, 0, 0, 0, 1, 9), E2(0, 0, 0, 0));
    applyStimulus("iss9_again", S(0, 0, 0, 0, 0, 1, 1, 9, 0, 0), E2(0, 0, 0, 1));
    applyStimulus("rs9_busy",   S(0, 0, 0, 0, 9, 1, 0, 0, 0, 0), E2(0, 0, 1, 0));

    // x4: count 1, then issue + writeback + kill together nets to zero.
    applyStimulus("iss4",     S(0, 0, 0, 0, 0, 1, 1, 4, 0, 0), E2(0, 0, 0, 1));
    applyStimulus("triple4",  S(1, 4, 32'h44, 0, 0, 1, 1, 4, 1, 4), E2(0, 0, 0, 1));
    applyStimulus("x4_zero",  S(0, 0, 0, 4, 0, 1, 0, 0, 0, 0), E2(32'h44, 0, 0, 1));
    // Double decrement of a zero counter must clamp, not wrap to max.
    applyStimulus("dec_zero", S(1, 4, 32'h55, 4, 0, 1, 0, 0, 1, 4),
                  E(32'h55, 0, 0, 1, 32'h44, 0, 0, 1));
    applyStimulus("x4_clamp", S(0, 0, 0, 4, 0, 1, 1, 4, 0, 0), E2(32'h55, 0, 0, 1));

    // x0 destination never counts, so repeated issues never stall.
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("iss_x0_%0d", i), S(0, 0, 0, 0, 0, 1, 1, 0, 0, 0), E2(0, 0, 0, 1));

    // Count 3 is still busy despite a same-cycle writeback.
    applyStimulus("rs9_cnt3_wb", S(1, 9, 32'h99, 9, 0, 1, 0, 0, 0, 0),
                  E(32'h99, 0, 1, 0, 0, 0, 1, 0));
    applyStimulus("pre_reset",   S(0, 0, 0, 5, 7, 0, 0, 0, 0, 0),
                  E2(32'hDEADBEEF, 32'hA5A5A5A5, 0, 0));

    applyAsyncReset("async_rst", S(1, 5, 32'h77, 5, 9, 1, 1, 9, 0, 0), E2(0, 0, 0, 1));
    releaseReset();

    applyStimulus("post_rst_a", S(0, 0, 0, 9, 5, 1, 1, 9, 0, 0), E2(0, 0, 0, 1));
    applyStimulus("post_rst_b", S(0, 0, 0, 7, 3, 1, 0, 0, 0, 0), E2(0, 0, 0, 1));
    applyStimulus("idle",       S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), E2(0, 0, 0, 0));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
